bcd_to_float: RTL and testbench
===============================

// Module: bcd_to_float
// PURPOSE
// - Input-side encoder for the FPU: turns a stream of decimal (BCD) digits, most significant
//   first, into the 7-bit exponent / 15-bit mantissa float format that the fpu add/sub core uses.
// - Number format: value = (m/2^14) * 2^e. e is 7-bit two's complement. m[14] = 1 when normalised.
// - Zero is encoded as e = 7'h40 (-64), m = 15'h0000.
// - Sits between the keypad/host digit interface and the register file feeding the fpu operands.
// PARAMETERS
// - DIGITS  5  maximum digits per number, legal range 1..5; the 17-bit accumulator holds 99999
// PORTS
// - clk          in   1   clock
// - reset        in   1   synchronous, active-high reset
// - digit_valid  in   1   a digit is present on digit
// - digit        in   4   BCD digit; values 10..15 are illegal
// - digit_last   in   1   qualifies digit as the final digit of the number
// - digit_ready  out  1   block accepts a digit this cycle; high only in ACCEPT
// - res_valid    out  1   one-cycle pulse: res_e/res_m/err are updated
// - res_e        out  7   result exponent; held until the next res_valid
// - res_m        out  15  result mantissa; held until the next res_valid
// - err          out  1   illegal digit or too many digits seen in this number; held with the result
// - idle         out  1   high in ACCEPT with no digits taken yet (count == 0)
// BEHAVIOUR
// - Reset: state = ACCEPT, acc = 0, count = 0, shift count s = 0.
//   Outputs reset to res_e = 0, res_m = 0, res_valid = 0, err = 0.
//   Reset mid-conversion abandons the number and leaves no partial result on the outputs.
// - Handshake: a digit transfers when digit_valid & digit_ready. Upstream holds digit/digit_last
//   stable until the transfer happens.
// - ACCEPT: on a transfer, latch the digit (digits > 9 clamp to 9 and set the err flag), count++,
//   then go to MUL. digit_ready = 1 only in this state.
// - MUL (1 cycle): acc <= (acc<<3) + (acc<<1) + dig, 17-bit.
//   If the digit was last, or count == DIGITS, go to NORM; otherwise go back to ACCEPT.
//   Reaching count == DIGITS without digit_last forces the end of the number and sets err.
//   The next digit after the forced end starts a new number.
// - NORM (1 cycle per step): if acc == 0, go to PACK directly.
//   Else, while acc[16] == 0: acc <= acc<<1 and s++. Go to PACK once acc[16] == 1.
// - PACK (1 cycle): res_m = acc[16:2] and res_e = 16 - s. If acc == 0: res_e = 7'h40, res_m = 0.
//   In this cycle, pulse res_valid, drive err, then clear acc/count/s/err and go to ACCEPT.
// - Latency: 2 cycles per digit (transfer + MUL), plus s+1 NORM cycles, plus 1 PACK cycle.
//   The worst case for one digit "1" is 2 + 17 + 1 cycles.
// - No upstream-driven state changes in MUL, NORM or PACK: digit_ready = 0 there.
// - Exponent range is 0..16 for nonzero results, so the exponent cannot overflow.
// CONFIGURATION
// - BCD_ROUND_EN defined: PACK rounds to nearest by adding acc[1] to acc[16:2].
//   If that carries out (mantissa 15'h7FFF + 1), then res_m = 15'h4000 and res_e = 17 - s.
// - BCD_ROUND_EN undefined: truncate; acc[1:0] is discarded.
// TESTING
// - Reset, then digit "1" with last -> after 20 cycles res_valid, res_e = 0, res_m = 15'h4000, err = 0.
// - "1","0" (last on 0) -> res_e = 3, res_m = 15'h5000.
// - "9","9","9","9","9" -> res_e = 16, res_m = 15'h61A7 (truncate); 15'h61A8 with BCD_ROUND_EN.
// - "0" with last -> res_e = 7'h40, res_m = 0. Also check digit_ready is low in MUL, NORM and PACK.
// - Digit 4'hC, last -> treated as 9: res_e = 3, res_m = 15'h4800, err = 1.
//   Then a clean "1" -> err = 0.
// - 6 digits "1" with no last -> result for "11111" with err = 1 (res_e = 13, res_m = 15'h56CE).
//   The 6th digit starts a new number. Reset asserted during NORM -> no res_valid, outputs at 0.

Source files
------------

// File: rtl/bcd_to_float_if.sv
// rtl/bcd_to_float_if.sv - digit stream in / float result out bundle for bcd_to_float
// Signals:
//   digit_valid, digit[3:0], digit_last : upstream digit stream (master drives)
//   digit_ready                         : block accepts a digit this cycle
//   res_valid, res_e[6:0], res_m[14:0]  : result pulse and held float result
//   err                                 : illegal digit / too many digits, held with result
//   idle                                : waiting for the first digit of a number
// Modports: master = digit source / result sink, slave = converter.
interface bcd_to_float_if;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        digit_last;
    logic        digit_ready;
    logic        res_valid;
    logic [6:0]  res_e;
    logic [14:0] res_m;
    logic        err;
    logic        idle;

    modport master (
        output digit_valid, digit, digit_last,
        input  digit_ready, res_valid, res_e, res_m, err, idle
    );

    modport slave (
        input  digit_valid, digit, digit_last,
        output digit_ready, res_valid, res_e, res_m, err, idle
    );
endinterface

// File: rtl/bcd_to_float.sv
// rtl/bcd_to_float.sv - BCD digit stream to 7-bit exponent / 15-bit mantissa float encoder
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : bcd_to_float_if.slave (digit stream in, result out)
// Parameter DIGITS (1..5): maximum digits per number.
// Optional macro BCD_ROUND_EN: round-to-nearest on pack instead of truncation.
// Result value = (res_m / 2^14) * 2^res_e; zero is res_e = 7'h40, res_m = 0.
module bcd_to_float #(
    parameter int DIGITS = 5
) (
    input  logic          clk,
    input  logic          reset,
    bcd_to_float_if.slave bus
);

    typedef enum logic [1:0] {ACCEPT, MUL, NORM, PACK} state_t;

    state_t      state, state_next;
    logic [16:0] acc;
    logic [2:0]  count;
    logic [4:0]  s;
    logic [3:0]  dig;
    logic        dig_last;
    logic        err_acc;
    logic        res_valid_q;
    logic [6:0]  res_e_q;
    logic [14:0] res_m_q;
    logic        err_q;

    logic        take;
    logic        count_full;
    logic [6:0]  pack_e;
    logic [14:0] pack_m;

    assign bus.digit_ready = (state == ACCEPT);
    assign take            = bus.digit_valid && (state == ACCEPT);
    assign count_full      = (count == DIGITS[2:0]);
    assign bus.idle        = (state == ACCEPT) && (count == 3'd0);
    assign bus.res_valid   = res_valid_q;
    assign bus.res_e       = res_e_q;
    assign bus.res_m       = res_m_q;
    assign bus.err         = err_q;

    always_ff @(posedge clk) begin
        if (reset) state <= ACCEPT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCEPT: if (take) state_next = MUL;
            MUL:    state_next = (dig_last || count_full) ? NORM : ACCEPT;
            NORM:   if (acc == 17'd0 || acc[16]) state_next = PACK;
            PACK:   state_next = ACCEPT;
            default: state_next = ACCEPT;
        endcase
    end

`ifdef BCD_ROUND_EN
    logic [15:0] mant_sum;
`endif

    // Normalised acc has its MSB at bit 16, so the mantissa is acc[16:2]
    // and the exponent counts back the left shifts taken in NORM.
    always_comb begin
        pack_e = 7'd16 - {2'b00, s};
        pack_m = acc[16:2];
`ifdef BCD_ROUND_EN
        mant_sum = {1'b0, acc[16:2]} + {15'd0, acc[1]};
        pack_m   = mant_sum[14:0];
        // 15'h7FFF rounding up wraps to the next binade.
        if (mant_sum[15]) begin
            pack_m = 15'h4000;
            pack_e = 7'd17 - {2'b00, s};
        end
`endif
        if (acc == 17'd0) begin
            pack_e = 7'h40;
            pack_m = 15'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc         <= 17'd0;
            count       <= 3'd0;
            s           <= 5'd0;
            dig         <= 4'd0;
            dig_last    <= 1'b0;
            err_acc     <= 1'b0;
            res_valid_q <= 1'b0;
            res_e_q     <= 7'd0;
            res_m_q     <= 15'd0;
            err_q       <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            case (state)
                ACCEPT: begin
                    if (take) begin
                        dig      <= (bus.digit > 4'd9) ? 4'd9 : bus.digit;
                        dig_last <= bus.digit_last;
                        count    <= count + 3'd1;
                        if (bus.digit > 4'd9) err_acc <= 1'b1;
                    end
                end
                MUL: begin
                    acc <= (acc << 3) + (acc << 1) + {13'd0, dig};
                    // Number cut off at the digit limit without a last marker.
                    if (!dig_last && count_full) err_acc <= 1'b1;
                end
                NORM: begin
                    if (acc != 17'd0 && !acc[16]) begin
                        acc <= acc << 1;
                        s   <= s + 5'd1;
                    end
                end
                PACK: begin
                    res_valid_q <= 1'b1;
                    res_e_q     <= pack_e;
                    res_m_q     <= pack_m;
                    err_q       <= err_acc;
                    acc         <= 17'd0;
                    count       <= 3'd0;
                    s           <= 5'd0;
                    err_acc     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_float.sv
// tb/tb_bcd_to_float.sv - self-checking bench for bcd_to_float with a decimal reference model
module tb_bcd_to_float;
    localparam int DIGITS = 5;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    bcd_to_float_if bus ();

    bcd_to_float #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Float encoding from the number's value: MSB position p gives the
    // exponent, mantissa is v scaled so that its MSB lands on bit 14.
    function automatic void float_ref(input longint v, output longint e,
                                      output longint m, output longint s);
        longint p;
        if (v == 0) begin
            e = 'h40; m = 0; s = 0;
            return;
        end
        p = 0;
        while ((longint'(1) << (p + 1)) <= v) p++;
        s = 16 - p;
        e = p;
`ifdef BCD_ROUND_EN
        m = ((v * (longint'(1) << 15)) / (longint'(1) << p) + 1) / 2;
        if (m == 32768) begin
            m = 16384;
            e = p + 1;
        end
`else
        m = (v * (longint'(1) << 14)) / (longint'(1) << p);
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send_digit(input logic [3:0] d, input logic l);
        int n;
        bus.digit_valid = 1'b1;
        bus.digit       = d;
        bus.digit_last  = l;
        n = 0;
        while (!bus.digit_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ready_timeout", 0, 1);
        @(negedge clk);
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.digit_last  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input longint exp_e, input longint exp_m,
                               input longint exp_err, input longint exp_lat);
        int  n;
        bit  seen;
        bit  busy_ready;
        seen = 0;
        busy_ready = 0;
        n = 0;
        while (!seen && n < 60) begin
            @(negedge clk);
            n++;
            if (bus.res_valid) seen = 1;
            else if (bus.digit_ready) busy_ready = 1;
        end
        check({tag, "_seen"}, seen, 1);
        if (seen) begin
            check({tag, "_e"}, bus.res_e, exp_e);
            check({tag, "_m"}, bus.res_m, exp_m);
            check({tag, "_err"}, bus.err, exp_err);
            check({tag, "_lat"}, n, exp_lat);
            check({tag, "_busy_ready"}, busy_ready, 0);
            @(negedge clk);
            check({tag, "_pulse"}, bus.res_valid, 0);
            check({tag, "_hold_m"}, bus.res_m, exp_m);
        end
    endtask

    longint m_acc, m_cnt, m_err;

    initial begin
        longint e, m, s;
        bit     rv_seen;
        checks   = 0;
        failures = 0;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.digit_last  = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_res_e", bus.res_e, 0);
        check("rst_res_m", bus.res_m, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_err", bus.err, 0);
        check("rst_ready", bus.digit_ready, 1);
        check("rst_idle", bus.idle, 1);
        reset = 1'b0;
        @(negedge clk);

        send_digit(4'd1, 1'b1);
        wait_result("one", 0, 'h4000, 0, 19);

        send_digit(4'd1, 1'b0);
        check("mid_idle", bus.idle, 0);
        send_digit(4'd0, 1'b1);
        wait_result("ten", 3, 'h5000, 0, 16);

        for (int i = 0; i < 5; i++) send_digit(4'd9, i == 4);
`ifdef BCD_ROUND_EN
        wait_result("n99999", 16, 'h61A8, 0, 3);
`else
        wait_result("n99999", 16, 'h61A7, 0, 3);
`endif

        send_digit(4'd0, 1'b1);
        wait_result("zero", 'h40, 0, 0, 3);

        send_digit(4'hC, 1'b1);
        wait_result("illegal", 3, 'h4800, 1, 16);
        send_digit(4'd1, 1'b1);
        wait_result("clean", 0, 'h4000, 0, 19);

        for (int i = 0; i < 5; i++) send_digit(4'd1, 1'b0);
        wait_result("forced", 13, 'h56CE, 1, 6);
        send_digit(4'd1, 1'b0);
        send_digit(4'd0, 1'b1);
        wait_result("after_forced", 3, 'h5000, 0, 16);

        // Randomized digit stream against the decimal model.
        m_acc = 0; m_cnt = 0; m_err = 0;
        for (int i = 0; i < 60; i++) begin
            logic [3:0] d;
            logic       l;
            longint     dv;
            d  = 4'($urandom_range(0, 11));
            l  = ($urandom_range(0, 3) == 0) || (i == 59);
            dv = (d > 9) ? 9 : longint'(d);
            if (d > 9) m_err = 1;
            m_acc = m_acc * 10 + dv;
            m_cnt++;
            send_digit(d, l);
            if (l || m_cnt == DIGITS) begin
                if (!l) m_err = 1;
                float_ref(m_acc, e, m, s);
                wait_result("rand", e, m, m_err, s + 3 - (m_cnt - 1) * 0);
                m_acc = 0; m_cnt = 0; m_err = 0;
            end
        end

        // Reset in the middle of normalisation leaves no result behind.
        send_digit(4'd1, 1'b1);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rv_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.res_valid) rv_seen = 1;
        end
        check("norm_rst_no_valid", rv_seen, 0);
        check("norm_rst_res_e", bus.res_e, 0);
        check("norm_rst_res_m", bus.res_m, 0);
        check("norm_rst_err", bus.err, 0);
        check("norm_rst_idle", bus.idle, 1);

        send_digit(4'd1, 1'b1);
        wait_result("post_rst", 0, 'h4000, 0, 19);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
